// File: rtl/glitch_pulse_gen_if.sv
// Bundle of control, timing-setting and status signals for glitch_pulse_gen.
// The master modport drives the settings and reads the status. The slave modport is the generator side.
interface glitch_pulse_gen_if #(
  parameter int unsigned CNT_W = 32
) ();

  // Sequence control
  logic             ARM;
  logic             MODE;
  logic             ABORT;
  logic             TRIG;

  // Timing settings, latched on ARM
  logic [CNT_W-1:0] DELAY;
  logic [CNT_W-1:0] WIDTH;
  logic [CNT_W-1:0] GAP;
  logic [CNT_W-1:0] COUNT;

  // Status and glitch output
  logic             GLITCH;
  logic             BUSY;
  logic             DONE;
  logic [CNT_W-1:0] PULSE_CNT;

  modport master (
    output ARM, MODE, ABORT, TRIG, DELAY, WIDTH, GAP, COUNT,
    input  GLITCH, BUSY, DONE, PULSE_CNT
  );

  modport slave (
    input  ARM, MODE, ABORT, TRIG, DELAY, WIDTH, GAP, COUNT,
    output GLITCH, BUSY, DONE, PULSE_CNT
  );

endinterface

// File: rtl/glitch_pulse_gen.sv
// Trigger-aligned, run-time programmable glitch pulse sequencer.
// Behaviour of the optional GLITCH_TRIG_SYNC_EN macro:
//   - When it is defined, TRIG passes through a 2-flop synchroniser before edge detection.
//     This adds 2 cycles of fixed latency.
//   - When it is undefined, TRIG must already be synchronous to CLK.
module glitch_pulse_gen #(
  parameter int unsigned CNT_W      = 32,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic               CLK,
  input  logic               RST,
  glitch_pulse_gen_if.slave  bus
);

  localparam logic IDLE_LVL = logic'(ACTIVE_LOW);
  localparam logic ACT_LVL  = ~logic'(ACTIVE_LOW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DLY,
    S_PULSE,
    S_GAP,
    S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             mode_q, mode_d;
  logic             glitch_q, glitch_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             trig_dly_q, trig_dly_d;

  logic             trig_s;
  logic             trig_edge;
  logic [CNT_W-1:0] width_m1;
  logic [CNT_W-1:0] gap_m1;
  logic             last_pulse;

`ifdef GLITCH_TRIG_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  // Two-stage synchroniser for the asynchronous TRIG pin
  always_comb begin
    sync1_d = bus.TRIG;
    sync2_d = sync1_q;
  end

  // Synchroniser flops
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign trig_s = sync2_q;
`else
  assign trig_s = bus.TRIG;
`endif

  // Rising-edge detect on the (optionally synchronised) trigger
  always_comb begin
    trig_dly_d = trig_s;
    trig_edge  = trig_s & ~trig_dly_q;
  end

  // Reload values: zero width/gap behaves as one cycle, and the down-counters run to zero
  always_comb begin
    width_m1   = (width_q == '0) ? '0 : width_q - CNT_W'(1);
    gap_m1     = (gap_q   == '0) ? '0 : gap_q   - CNT_W'(1);
    last_pulse = (count_q != '0) && ((pulse_cnt_q + CNT_W'(1)) == count_q);
  end

  // Next-state, counter, shadow-register and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    delay_d     = delay_q;
    width_d     = width_q;
    gap_d       = gap_q;
    count_d     = count_q;
    mode_d      = mode_q;

    if (bus.ABORT) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.ARM) begin
            delay_d     = bus.DELAY;
            width_d     = bus.WIDTH;
            gap_d       = bus.GAP;
            count_d     = bus.COUNT;
            mode_d      = bus.MODE;
            pulse_cnt_d = '0;
            if (bus.MODE) begin
              state_d = S_DLY;
              cnt_d   = bus.DELAY;
            end else begin
              state_d = S_ARMED;
            end
          end
        end
        S_ARMED: begin
          if (mode_q || trig_edge) begin
            state_d = S_DLY;
            cnt_d   = delay_q;
          end
        end
        S_DLY: begin
          if (cnt_q == '0) begin
            state_d = S_PULSE;
            cnt_d   = width_m1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_PULSE: begin
          if (cnt_q == '0) begin
            pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
            if (last_pulse) begin
              state_d = S_FIN;
            end else begin
              state_d = S_GAP;
              cnt_d   = gap_m1;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            state_d = S_PULSE;
            cnt_d   = width_m1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_FIN: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Outputs are decoded from the next state so they line up with the state register
    glitch_d = (state_d == S_PULSE) ? ACT_LVL : IDLE_LVL;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_FIN);
  end

  // State, counters, shadow settings and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pulse_cnt_q <= '0;
      delay_q     <= '0;
      width_q     <= '0;
      gap_q       <= '0;
      count_q     <= '0;
      mode_q      <= 1'b0;
      glitch_q    <= IDLE_LVL;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      trig_dly_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      delay_q     <= delay_d;
      width_q     <= width_d;
      gap_q       <= gap_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      glitch_q    <= glitch_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      trig_dly_q  <= trig_dly_d;
    end
  end

  assign bus.GLITCH    = glitch_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.PULSE_CNT = pulse_cnt_q;

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Directed bench for glitch_pulse_gen, built with ACTIVE_LOW=1 (active level 0).
// The variable rel counts clock edges since the start of the current scenario.
module tb_glitch_pulse_gen;

  localparam int unsigned CNT_W = 32;
  localparam logic ACT = 1'b0;
  localparam logic INA = 1'b1;
`ifdef GLITCH_TRIG_SYNC_EN
  localparam int TRIG_LAT = 2;
`else
  localparam int TRIG_LAT = 0;
`endif

  logic CLK = 1'b0;
  logic RST;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rel     = 0;
  int   pcyc;

  glitch_pulse_gen_if #(.CNT_W(CNT_W)) bus ();

  glitch_pulse_gen #(.CNT_W(CNT_W), .ACTIVE_LOW(1'b1)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Advance one clock and sample 1 time unit after the edge
  task automatic step();
    @(posedge CLK);
    #1;
    rel++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s rel=%0d observed=%0h expected=%0h", tag, rel, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic m, input int d, input int w, input int g, input int c);
    bus.MODE  = m;
    bus.DELAY = 32'(d);
    bus.WIDTH = 32'(w);
    bus.GAP   = 32'(g);
    bus.COUNT = 32'(c);
  endtask

  initial begin
    RST = 1'b1;
    bus.ARM = 1'b0; bus.ABORT = 1'b0; bus.TRIG = 1'b0;
    set_cfg(1'b0, 0, 0, 0, 0);

    // Reset values while reset is held and after release
    #1;
    chk("rst_glitch", 32'(bus.GLITCH), 32'(INA));
    chk("rst_busy", 32'(bus.BUSY), 0);
    chk("rst_done", 32'(bus.DONE), 0);
    chk("rst_pcnt", bus.PULSE_CNT, 0);
    repeat (3) step();
    RST = 1'b0;
    step();
    chk("rel_glitch", 32'(bus.GLITCH), 32'(INA));
    chk("rel_busy", 32'(bus.BUSY), 0);
    chk("rel_pcnt", bus.PULSE_CNT, 0);

    // Scenario A: free-run with DELAY=0, WIDTH=25, GAP=5, COUNT=3, and ARM sampled at edge 10
    rel = 0;
    set_cfg(1'b1, 0, 25, 5, 3);
    while (rel < 9) step();
    bus.ARM = 1'b1;
    step();
    bus.ARM = 1'b0;
    set_cfg(1'b0, 9, 7, 1, 1);
    chk("a_busy_rise", 32'(bus.BUSY), 1);
    chk("a_glitch_dly", 32'(bus.GLITCH), 32'(INA));
    while (rel < 97) begin
      step();
      chk("a_glitch", 32'(bus.GLITCH),
          32'(((rel >= 11 && rel <= 35) || (rel >= 41 && rel <= 65) || (rel >= 71 && rel <= 95)) ? ACT : INA));
      chk("a_done", 32'(bus.DONE), 32'(rel == 96));
      chk("a_busy", 32'(bus.BUSY), 32'(rel <= 96));
    end
    chk("a_pcnt", bus.PULSE_CNT, 3);

    // Scenario B: triggered mode. TRIG is already high at ARM and falls at edge 30; the real edge comes before edge 50
    rel = 0;
    set_cfg(1'b0, 100, 1, 1, 1);
    bus.TRIG = 1'b1;
    while (rel < 9) step();
    bus.ARM = 1'b1;
    step();
    bus.ARM = 1'b0;
    set_cfg(1'b1, 0, 4, 4, 0);
    chk("b_busy_armed", 32'(bus.BUSY), 1);
    pcyc = 151 + TRIG_LAT;
    while (rel < pcyc + 5) begin
      if (rel == 29) bus.TRIG = 1'b0;
      if (rel == 49) bus.TRIG = 1'b1;
      step();
      chk("b_glitch", 32'(bus.GLITCH), 32'((rel == pcyc) ? ACT : INA));
      chk("b_done", 32'(bus.DONE), 32'(rel == pcyc + 1));
      chk("b_busy", 32'(bus.BUSY), 32'(rel <= pcyc + 1));
    end
    chk("b_pcnt", bus.PULSE_CNT, 1);
    bus.TRIG = 1'b0;

    // Scenario C: endless alternating pulses (COUNT=0, WIDTH=0, GAP=0), then ABORT sampled at edge 41
    rel = 0;
    set_cfg(1'b1, 0, 0, 0, 0);
    while (rel < 9) step();
    bus.ARM = 1'b1;
    step();
    bus.ARM = 1'b0;
    while (rel < 40) begin
      step();
      chk("c_glitch", 32'(bus.GLITCH), 32'((rel % 2 == 1) ? ACT : INA));
      chk("c_done", 32'(bus.DONE), 0);
    end
    bus.ABORT = 1'b1;
    step();
    bus.ABORT = 1'b0;
    chk("c_abort_glitch", 32'(bus.GLITCH), 32'(INA));
    chk("c_abort_busy", 32'(bus.BUSY), 0);
    chk("c_abort_done", 32'(bus.DONE), 0);
    chk("c_abort_pcnt", bus.PULSE_CNT, 15);
    repeat (4) begin
      step();
      chk("c_idle_done", 32'(bus.DONE), 0);
      chk("c_idle_glitch", 32'(bus.GLITCH), 32'(INA));
    end

    // Scenario D: ARM is pulsed during DLY and during GAP, then ARM and ABORT are asserted together in IDLE
    rel = 0;
    set_cfg(1'b1, 20, 3, 2, 2);
    while (rel < 9) step();
    bus.ARM = 1'b1;
    step();
    bus.ARM = 1'b0;
    while (rel < 42) begin
      if (rel == 14 || rel == 34) begin
        set_cfg(1'b1, 0, 9, 9, 5);
        bus.ARM = 1'b1;
      end
      step();
      bus.ARM = 1'b0;
      if (rel == 35) chk("d_pcnt_mid", bus.PULSE_CNT, 1);
      chk("d_glitch", 32'(bus.GLITCH),
          32'(((rel >= 31 && rel <= 33) || (rel >= 36 && rel <= 38)) ? ACT : INA));
      chk("d_done", 32'(bus.DONE), 32'(rel == 39));
      chk("d_busy", 32'(bus.BUSY), 32'(rel <= 39));
    end
    chk("d_pcnt_end", bus.PULSE_CNT, 2);
    set_cfg(1'b1, 0, 1, 1, 1);
    bus.ARM   = 1'b1;
    bus.ABORT = 1'b1;
    step();
    bus.ARM   = 1'b0;
    bus.ABORT = 1'b0;
    chk("d_armabort_busy", 32'(bus.BUSY), 0);
    chk("d_armabort_pcnt", bus.PULSE_CNT, 2);
    repeat (5) begin
      step();
      chk("d_armabort_glitch", 32'(bus.GLITCH), 32'(INA));
      chk("d_armabort_idle", 32'(bus.BUSY), 0);
    end

    // Scenario E: asynchronous reset in the middle of a pulse
    rel = 0;
    set_cfg(1'b1, 0, 10, 1, 1);
    while (rel < 9) step();
    bus.ARM = 1'b1;
    step();
    bus.ARM = 1'b0;
    while (rel < 13) step();
    chk("e_glitch_on", 32'(bus.GLITCH), 32'(ACT));
    #2;
    RST = 1'b1;
    #1;
    chk("e_async_glitch", 32'(bus.GLITCH), 32'(INA));
    chk("e_async_busy", 32'(bus.BUSY), 0);
    chk("e_async_pcnt", bus.PULSE_CNT, 0);
    step();
    RST = 1'b0;
    step();
    chk("e_after_glitch", 32'(bus.GLITCH), 32'(INA));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/glitch_pulse_gen.md
# glitch_pulse_gen

Parametrised, trigger-aligned glitch pulse generator for the fault-injection rig. It replaces the fixed free-running glitch blinker with a run-time programmable sequencer. After an optional external trigger edge, it waits a programmable delay, then emits a programmable number of glitch pulses of programmable width and spacing. GLITCH drives the crowbar/MOSFET pin on the PMOD header; TRIG typically comes from the target's reset line or a UART marker.

## Interface

Parameters:
- CNT_W, 32: width of DELAY, WIDTH, GAP and COUNT inputs and of all internal counters.
- ACTIVE_LOW, 0: 1 means the GLITCH active level is 0 and its idle level is 1.

Ports:
- CLK  in  1  system clock (12 MHz on iCEBreaker).
- RST  in  1  asynchronous, active-high reset.
- ARM  in  1  start request; sampled only in IDLE.
- MODE  in  1  0 = wait for a TRIG rising edge, 1 = free-run (start on ARM).
- ABORT  in  1  cancels any sequence; has priority over everything except RST.
- TRIG  in  1  external trigger, asynchronous to CLK.
- DELAY  in  CNT_W  cycles from trigger to the first pulse.
- WIDTH  in  CNT_W  pulse width in cycles; 0 is treated as 1.
- GAP  in  CNT_W  inactive cycles between pulses; 0 is treated as 1.
- COUNT  in  CNT_W  number of pulses; 0 means repeat until ABORT.
- GLITCH  out  1  registered glitch output.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse when a finite sequence completes.
- PULSE_CNT  out  CNT_W  pulses emitted since the last ARM; wraps modulo 2^CNT_W.

## Operation

- States: IDLE, ARMED, DLY, PULSE, GAP, FIN.
- IDLE:
  - ARM=1 latches DELAY, WIDTH, GAP, COUNT and MODE into shadow registers and clears PULSE_CNT.
  - Next state is ARMED when MODE=0, or DLY when MODE=1.
  - Inputs changed after the ARM cycle have no effect until the next ARM.
- ARMED: waits for a TRIG rising edge (edge = synchronised TRIG high and its registered copy low), then goes to DLY.
  - A TRIG that is already high at ARM time does not count as an edge.
- DLY: counts the shadow DELAY value, then goes to PULSE. With DELAY=0 it moves to PULSE immediately.
- PULSE:
  - GLITCH is at its active level for exactly max(WIDTH,1) cycles.
  - PULSE_CNT increments on the last cycle of the pulse.
  - If that was the COUNT-th pulse (COUNT≠0), next state is FIN; otherwise GAP.
- GAP: GLITCH is inactive for exactly max(GAP,1) cycles, then the state returns to PULSE.
- FIN: DONE=1 for one cycle, then IDLE.
- ABORT=1 in any state: next state is IDLE and GLITCH goes inactive on the next edge. DONE is not asserted.
  - If ABORT and ARM are both high in IDLE, ABORT wins and nothing is latched.
- ARM in any state other than IDLE is ignored.
- All counters are CNT_W wide. Down-counters load value-1, so there is no overflow case.
- RST (asynchronous):
  - state goes to IDLE;
  - GLITCH = inactive level (ACTIVE_LOW ? 1 : 0);
  - BUSY = 0, DONE = 0, PULSE_CNT = 0;
  - shadow registers = 0.
- Asserting RST mid-pulse terminates the pulse immediately, without waiting for a clock edge.

## Timing

- Define cycle t0 as the first rising edge at which the TRIG edge is detected. In MODE=1, t0 is the ARM cycle.
- The first active GLITCH cycle begins at edge t0+1+DELAY.
- Pulse n (counting from 0) begins at t0+1+DELAY+n·(W+G), where W=max(WIDTH,1) and G=max(GAP,1).
- DONE is high in the cycle immediately after the last active cycle. BUSY falls in the cycle after DONE.
- BUSY rises in the cycle after ARM is accepted.
- GLITCH, BUSY, DONE and PULSE_CNT are all registered outputs; none has a combinational path from an input.
- TRIG-to-t0 latency:
  - 2 cycles with the synchroniser;
  - 0 cycles without it (the edge is seen on the first clock edge at which TRIG is high).

## Configuration

- GLITCH_TRIG_SYNC_EN defined:
  - TRIG passes through a 2-flop synchroniser before edge detection;
  - this adds a fixed 2-cycle latency to t0;
  - required whenever TRIG comes from an asynchronous target pin.
- GLITCH_TRIG_SYNC_EN undefined:
  - TRIG feeds the edge-detect register directly, giving minimum and deterministic latency;
  - this is only legal when TRIG is already synchronous to CLK.
- All other behaviour is identical with or without the macro.

## Test plan

- Reset with ACTIVE_LOW=1, then release RST:
  - GLITCH=1, BUSY=0, PULSE_CNT=0.
  - Asserting RST during PULSE forces GLITCH=1 asynchronously.
- MODE=1, DELAY=0, WIDTH=25, GAP=5, COUNT=3, ARM at cycle 10:
  - GLITCH active in cycles 11–35, 41–65 and 71–95;
  - DONE at cycle 96; PULSE_CNT=3.
- MODE=0, DELAY=100, WIDTH=1, COUNT=1, no synchroniser, TRIG rises before edge 50:
  - GLITCH active only in cycle 151;
  - a TRIG held high before ARM produces no pulse.
- Same as the previous scenario with GLITCH_TRIG_SYNC_EN defined:
  - pulse moves to cycle 153.
- MODE=1, COUNT=0, WIDTH=0, GAP=0:
  - GLITCH alternates active/inactive every cycle indefinitely;
  - ABORT at an arbitrary cycle gives GLITCH inactive and BUSY=0 on the next edge, with no DONE.
- ARM pulsed during DLY, with ARM and ABORT asserted together in IDLE:
  - neither changes state or the latched settings;
  - PULSE_CNT is unchanged.
